// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: sequential forward AES SubBytes over valid/ready, BYTES_PER_CYCLE bytes per clock.
// Optional AES_SBOX_PIPE_EN: registers S-box outputs for one cycle before write-back (+1 cycle latency).
module aes_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 1,
    parameter int DATA_WIDTH      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int G  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam int W  = BYTES_PER_CYCLE * 8;
    // Forward S-box, entry 0x00 in the top byte; row r holds entries r0..rF.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16}) || DATA_WIDTH != 8) begin : g_bad_cfg
        $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1/2/4/8/16 and DATA_WIDTH must be 8");
    end

`ifdef AES_SBOX_PIPE_EN
    typedef enum logic [1:0] {IDLE, BUSY, PIPE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [127:0]    work_q, work_d;
    logic [CW-1:0]   k_q, k_d;
    logic [W-1:0]    grp_in, grp_sub;
    logic            last;

    assign grp_in    = work_q[127 - W * int'(k_q) -: W];
    assign last      = (k_q == CW'(G - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;
`ifdef AES_SBOX_PIPE_EN
    assign busy      = (state_q == BUSY) || (state_q == PIPE);
`else
    assign busy      = (state_q == BUSY);
`endif

    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
        assign grp_sub[i*8 +: 8] = SBOX[2047 - 8 * int'(grp_in[i*8 +: 8]) -: 8];
    end

`ifdef AES_SBOX_PIPE_EN
    logic [W-1:0] pipe_q, pipe_d;

    // Holds the S-box result of the previous group until it is written back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end
`endif

    // Next-state, group counter and in-place working register update.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        k_d     = k_q;
`ifdef AES_SBOX_PIPE_EN
        pipe_d  = pipe_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                work_d  = in_data;
                k_d     = '0;
                state_d = BUSY;
            end
            BUSY: begin
                k_d = last ? '0 : k_q + 1'b1;
`ifdef AES_SBOX_PIPE_EN
                pipe_d = grp_sub;
                if (k_q != '0) work_d[127 - W * int'(k_q - 1'b1) -: W] = pipe_q;
                state_d = last ? PIPE : BUSY;
`else
                work_d[127 - W * int'(k_q) -: W] = grp_sub;
                state_d = last ? DONE : BUSY;
`endif
            end
`ifdef AES_SBOX_PIPE_EN
            PIPE: begin
                work_d[127 - W * (G - 1) -: W] = pipe_q;
                state_d = DONE;
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, working register and group counter; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            k_q     <= k_d;
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: directed bench for aes_sub_bytes_seq at BYTES_PER_CYCLE = 1, 4 and 16.
module tb_aes_sub_bytes_seq;
`ifdef AES_SBOX_PIPE_EN
    localparam int PL = 1;
`else
    localparam int PL = 0;
`endif

    logic         clk = 0;
    logic         rst_n = 0;
    logic [2:0]   in_valid = '0;
    logic [2:0]   out_ready = '0;
    logic [2:0]   in_ready, out_valid, busy;
    logic [127:0] in_data [3];
    logic [127:0] out_data [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox_m [256];
    logic [7:0] inv_m [256];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        aes_sub_bytes_seq #(
            .BYTES_PER_CYCLE(i == 0 ? 1 : (i == 1 ? 4 : 16)),
            .DATA_WIDTH(8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[i]), .in_ready(in_ready[i]), .in_data(in_data[i]),
            .out_valid(out_valid[i]), .out_ready(out_ready[i]), .out_data(out_data[i]),
            .busy(busy[i])
        );
    end

    typedef struct {
        int           d;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    function automatic int bpc(input int d);
        return d == 0 ? 1 : (d == 1 ? 4 : 16);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_m(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = sbox_m[s[127 - 8*j -: 8]];
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction on DUT d: accept, measure latency, return result, complete handshake.
    task automatic run(input int d, input logic [127:0] din, input string nm, output logic [127:0] got);
        int c;
        c = 0;
        while (!in_ready[d] && c < 100) begin @(posedge clk); #1; c++; end
        in_valid[d] = 1'b1;
        in_data[d]  = din;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        c = 0;
        while (!out_valid[d] && c < 100) begin @(posedge clk); #1; c++; end
        check({nm, "_latency"}, 128'(c), 128'(16 / bpc(d) + PL));
        got = out_data[d];
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check({nm, "_in_ready_after"}, 128'(in_ready[d]), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [8];
        logic [127:0] got, snap, b2b_in [3], od, st;
        logic [7:0]   inv, s;
        logic         ok, ok_inv, acc, ov;
        int           c, ni, no, acc_c [3];

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = s;
            inv_m[s]  = 8'(x);
        end

        vecs[0] = '{0, {8'h00, {15{8'h00}}}, {8'h63, {15{8'h63}}}};
        vecs[1] = '{0, {8'h53, {15{8'h00}}}, {8'hed, {15{8'h63}}}};
        vecs[2] = '{0, {8'hff, {15{8'h00}}}, {8'h16, {15{8'h63}}}};
        vecs[3] = '{0, {8'h01, {15{8'h00}}}, {8'h7c, {15{8'h63}}}};
        vecs[4] = '{0, APPB_IN, APPB_OUT};
        vecs[5] = '{1, APPB_IN, APPB_OUT};
        vecs[6] = '{2, APPB_IN, APPB_OUT};
        vecs[7] = '{2, {16{8'h00}}, {16{8'h63}}};

        for (int d = 0; d < 3; d++) in_data[d] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_in_ready", 128'(in_ready[d]), 128'(1));
            check("reset_out_valid", 128'(out_valid[d]), 128'(0));
            check("reset_busy", 128'(busy[d]), 128'(0));
            check("reset_out_data", out_data[d], 128'(0));
        end

        for (int v = 0; v < 8; v++) begin
            run(vecs[v].d, vecs[v].din, $sformatf("vec%0d", v), got);
            check($sformatf("vec%0d_data", v), got, vecs[v].dexp);
        end

        // Backpressure on BPC=1: result held, input side closed, in_valid pulses ignored.
        in_valid[0] = 1'b1;
        in_data[0]  = APPB_IN;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        c = 0;
        while (!out_valid[0] && c < 100) begin @(posedge clk); #1; c++; end
        snap = out_data[0];
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = i[0];
            in_data[0]  = {4{$urandom}};
            @(posedge clk); #1;
            if (out_data[0] !== snap || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) ok = 1'b0;
        end
        in_valid[0] = 1'b0;
        check("bp_stable", 128'(ok), 128'(1));
        check("bp_data", snap, APPB_OUT);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
        check("bp_release_out_valid", 128'(out_valid[0]), 128'(0));

        // Back-to-back on BPC=4 with continuous in_valid and out_ready.
        b2b_in[0] = APPB_IN;
        b2b_in[1] = {16{8'h53}};
        b2b_in[2] = 128'h000102030405060708090a0b0c0d0e0f;
        in_data[1] = b2b_in[0];
        in_valid[1] = 1'b1;
        out_ready[1] = 1'b1;
        ni = 0;
        no = 0;
        for (int cy = 0; cy < 100 && no < 3; cy++) begin
            acc = in_valid[1] & in_ready[1];
            ov  = out_valid[1];
            od  = out_data[1];
            @(posedge clk); #1;
            if (ov && no < 3) begin
                check($sformatf("b2b_out%0d", no), od, sub_m(b2b_in[no]));
                no++;
            end
            if (acc && ni < 3) begin
                acc_c[ni] = cy;
                ni++;
                if (ni < 3) in_data[1] = b2b_in[ni];
                else in_valid[1] = 1'b0;
            end
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b0;
        check("b2b_results", 128'(no), 128'(3));
        check("b2b_accepts", 128'(ni), 128'(3));
        check("b2b_spacing01", 128'(acc_c[1] - acc_c[0]), 128'(4 + 2 + PL));
        check("b2b_spacing12", 128'(acc_c[2] - acc_c[1]), 128'(4 + 2 + PL));

        // Reset while BPC=1 is at group 7.
        in_valid[0] = 1'b1;
        in_data[0]  = APPB_IN;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 128'(busy[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid[0]), 128'(0));
        check("rst_out_data", out_data[0], 128'(0));
        check("rst_busy", 128'(busy[0]), 128'(0));
        check("rst_in_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, {8'h53, {15{8'h00}}}, "post_rst", got);
        check("post_rst_data", got, {8'hed, {15{8'h63}}});

        // Every byte value through BPC=16, checked forward and through the inverse table.
        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = 8'(t * 16 + j);
            run(2, st, $sformatf("exh%0d", t), got);
            check($sformatf("exh%0d_fwd", t), got, sub_m(st));
            ok_inv = 1'b1;
            for (int j = 0; j < 16; j++) if (inv_m[got[127 - 8*j -: 8]] !== st[127 - 8*j -: 8]) ok_inv = 1'b0;
            check($sformatf("exh%0d_inv", t), 128'(ok_inv), 128'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
